// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared types for the instruction fetch line buffer
package fetch_pkg;

  localparam int WORDS_PER_LINE = 4;

  typedef logic [29:0]  iaddr_t;
  typedef logic [27:0]  lineaddr_t;
  typedef logic [127:0] line_t;

  typedef struct packed {
    line_t      data;
    lineaddr_t  addr;
    logic [1:0] start;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_line_queue.sv
// rtl/fetch_line_queue.sv - circular FIFO of fetched cache lines with flush
module fetch_line_queue
  import fetch_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush_i,
  input  logic             push_i,
  input  fetch_entry_t     push_entry_i,
  input  logic             pop_i,
  output fetch_entry_t     head_o,
  output logic [CNT_W-1:0] count_o,
  output logic             empty_o
);

  localparam int PTR_W = $clog2(DEPTH);

  fetch_entry_t     mem_q [DEPTH];
  logic [PTR_W-1:0] wr_q;
  logic [PTR_W-1:0] rd_q;
  logic [CNT_W-1:0] cnt_q;

  assign head_o  = mem_q[rd_q];
  assign count_o = cnt_q;
  assign empty_o = (cnt_q == '0);

  // Credits upstream guarantee push never hits a full queue, pop never an empty one.
  always_ff @(posedge clk) begin
    if (rst || flush_i) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push_i) begin
        mem_q[wr_q] <= push_entry_i;
        wr_q        <= wr_q + 1'b1;
      end
      if (pop_i) begin
        rd_q <= rd_q + 1'b1;
      end
      case ({push_i, pop_i})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

// File: rtl/fetch_line_buffer_stage.sv
// rtl/fetch_line_buffer_stage.sv - line-granular I-cache fetch with buffered bundle drain to decode
module fetch_line_buffer_stage
  import fetch_pkg::*;
#(
  parameter int          FETCH_WIDTH = 2,
  parameter int          QUEUE_DEPTH = 4,
  parameter logic [29:0] RESET_PC    = 30'h0
) (
  input  logic                      clk,
  input  logic                      rst,
  output logic                      cache_req_valid_o,
  input  logic                      cache_req_ready_i,
  output logic [27:0]               cache_req_addr_o,
  input  logic                      cache_resp_valid_i,
  input  logic [127:0]              cache_resp_data_i,
  input  logic                      redirect_valid_i,
  input  logic [29:0]               redirect_pc_i,
  output logic                      out_valid_o,
  input  logic                      out_ready_i,
  output logic [29:0]               out_pc_o,
  output logic [32*FETCH_WIDTH-1:0] out_enc_o,
  output logic [FETCH_WIDTH-1:0]    out_mask_o
);

  localparam int               CNT_W   = $clog2(QUEUE_DEPTH) + 1;
  localparam int               OCC_W   = CNT_W + 1;
  localparam logic [OCC_W-1:0] DEPTH_L = OCC_W'(QUEUE_DEPTH);
  localparam logic [2:0]       WPL     = 3'(WORDS_PER_LINE);

  iaddr_t           fpc_q, fpc_d;
  logic             inflight_q;
  lineaddr_t        req_line_q;
  logic [1:0]       req_start_q;
  logic [1:0]       adv_q, adv_d;
  logic [CNT_W-1:0] count;
  logic [OCC_W-1:0] occupancy;
  fetch_entry_t     head, push_entry;
  logic             q_empty, flush, accept, push, fire, pop;
  logic [1:0]       cur_off;
  logic [2:0]       lane_pos, n_lanes, end_pos;

  assign flush     = rst || redirect_valid_i;
  assign occupancy = {1'b0, count} + {{CNT_W{1'b0}}, inflight_q};

  // An outstanding request reserves a slot, so the queue can never overflow.
  assign cache_req_valid_o = !rst && !redirect_valid_i && (occupancy < DEPTH_L);
  assign cache_req_addr_o  = fpc_q[29:2];
  assign accept            = cache_req_valid_o && cache_req_ready_i;

  assign push             = cache_resp_valid_i && inflight_q && !flush;
  assign push_entry.data  = cache_resp_data_i;
  assign push_entry.addr  = req_line_q;
  assign push_entry.start = req_start_q;

  fetch_line_queue #(
    .DEPTH (QUEUE_DEPTH),
    .CNT_W (CNT_W)
  ) u_queue (
    .clk          (clk),
    .rst          (rst),
    .flush_i      (redirect_valid_i),
    .push_i       (push),
    .push_entry_i (push_entry),
    .pop_i        (pop),
    .head_o       (head),
    .count_o      (count),
    .empty_o      (q_empty)
  );

  assign cur_off     = head.start + adv_q;
  assign out_valid_o = !q_empty;
  assign out_pc_o    = {head.addr, cur_off};

  always_comb begin
    out_mask_o = '0;
    out_enc_o  = '0;
    n_lanes    = '0;
    lane_pos   = '0;
    for (int i = 0; i < FETCH_WIDTH; i++) begin
      lane_pos = {1'b0, cur_off} + 3'(i);
      if (lane_pos < WPL) begin
        out_mask_o[i]          = !q_empty;
        out_enc_o[32*i +: 32]  = head.data[{lane_pos[1:0], 5'b0} +: 32];
        n_lanes                = n_lanes + {2'b0, !q_empty};
      end
    end
  end

  // A redirect in the same cycle means decode's acceptance does not count here.
  assign fire    = !q_empty && out_ready_i && !flush;
  assign end_pos = {1'b0, cur_off} + n_lanes;
  assign pop     = fire && (end_pos == WPL);

  always_comb begin
    fpc_d = fpc_q;
    adv_d = adv_q;
    if (accept) begin
      fpc_d = {fpc_q[29:2] + 28'd1, 2'b00};
    end
    if (pop) begin
      adv_d = '0;
    end else if (fire) begin
      adv_d = adv_q + n_lanes[1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fpc_q       <= RESET_PC;
      inflight_q  <= 1'b0;
      adv_q       <= '0;
      req_line_q  <= '0;
      req_start_q <= '0;
    end else if (redirect_valid_i) begin
      fpc_q      <= redirect_pc_i;
      inflight_q <= 1'b0;
      adv_q      <= '0;
    end else begin
      fpc_q      <= fpc_d;
      inflight_q <= accept;
      adv_q      <= adv_d;
      if (accept) begin
        req_line_q  <= fpc_q[29:2];
        req_start_q <= fpc_q[1:0];
      end
    end
  end

endmodule

// File: tb/tb_fetch_line_buffer_stage.sv
// tb/tb_fetch_line_buffer_stage.sv - scoreboard bench for fetch_line_buffer_stage (widths 2 and 3)
module tb_fetch_line_buffer_stage;

  localparam int          FW    = 2;
  localparam int          QD    = 4;
  localparam logic [29:0] RPC   = 30'h0;

  typedef struct packed {
    logic [29:0]      pc;
    logic [32*FW-1:0] enc;
    logic [FW-1:0]    mask;
  } bundle_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst;
  logic             req_valid, req_ready, resp_valid, inject;
  logic [27:0]      req_addr;
  logic [127:0]     resp_data;
  logic             redirect_valid;
  logic [29:0]      redirect_pc;
  logic             out_valid, out_ready;
  logic [29:0]      out_pc;
  logic [32*FW-1:0] out_enc;
  logic [FW-1:0]    out_mask;

  logic             b_req_valid, b_req_ready, b_resp_valid, b_redirect_valid, b_out_valid, b_out_ready;
  logic [27:0]      b_req_addr;
  logic [127:0]     b_resp_data;
  logic [29:0]      b_redirect_pc, b_out_pc;
  logic [95:0]      b_out_enc;
  logic [2:0]       b_out_mask;

  fetch_line_buffer_stage #(.FETCH_WIDTH(FW), .QUEUE_DEPTH(QD), .RESET_PC(RPC)) dut (
    .clk(clk), .rst(rst),
    .cache_req_valid_o(req_valid), .cache_req_ready_i(req_ready), .cache_req_addr_o(req_addr),
    .cache_resp_valid_i(resp_valid), .cache_resp_data_i(resp_data),
    .redirect_valid_i(redirect_valid), .redirect_pc_i(redirect_pc),
    .out_valid_o(out_valid), .out_ready_i(out_ready), .out_pc_o(out_pc),
    .out_enc_o(out_enc), .out_mask_o(out_mask)
  );

  fetch_line_buffer_stage #(.FETCH_WIDTH(3), .QUEUE_DEPTH(4), .RESET_PC(30'h0)) dut_w3 (
    .clk(clk), .rst(rst),
    .cache_req_valid_o(b_req_valid), .cache_req_ready_i(b_req_ready), .cache_req_addr_o(b_req_addr),
    .cache_resp_valid_i(b_resp_valid), .cache_resp_data_i(b_resp_data),
    .redirect_valid_i(b_redirect_valid), .redirect_pc_i(b_redirect_pc),
    .out_valid_o(b_out_valid), .out_ready_i(b_out_ready), .out_pc_o(b_out_pc),
    .out_enc_o(b_out_enc), .out_mask_o(b_out_mask)
  );

  int checks = 0;
  int errors = 0;

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] enc_of(input logic [29:0] w);
    return {2'b01, w} ^ 32'h00A5_5A00;
  endfunction

  function automatic logic [127:0] line_data(input logic [27:0] l);
    logic [127:0] d;
    for (int k = 0; k < 4; k++) d[32*k +: 32] = enc_of({l, 2'(k)});
    return d;
  endfunction

  function automatic logic [32*FW-1:0] lane_bits(input logic [FW-1:0] m);
    logic [32*FW-1:0] r;
    for (int i = 0; i < FW; i++) r[32*i +: 32] = {32{m[i]}};
    return r;
  endfunction

  // One-cycle-latency cache models; inject forces a response with no request behind it.
  always @(posedge clk) begin
    resp_valid   <= (req_valid && req_ready) || inject;
    resp_data    <= inject ? line_data(28'hFFF_FFFF) : line_data(req_addr);
    b_resp_valid <= b_req_valid && b_req_ready;
    b_resp_data  <= line_data(b_req_addr);
  end

  bundle_t     exp_q[$];
  bundle_t     e;
  logic [27:0] exp_line;
  logic [1:0]  exp_off;
  int          acc_cnt = 0;
  int          cons_cnt = 0;

  task automatic push_line(input logic [27:0] l, input logic [1:0] off);
    bundle_t b;
    int pos, n;
    pos = int'(off);
    while (pos < 4) begin
      n = (4 - pos < FW) ? 4 - pos : FW;
      b.pc = {l, 2'(pos)};
      b.enc = '0;
      b.mask = '0;
      for (int i = 0; i < n; i++) begin
        b.mask[i] = 1'b1;
        b.enc[32*i +: 32] = enc_of({l, 2'(pos + i)});
      end
      exp_q.push_back(b);
      pos += n;
    end
  endtask

  // Accepted requests push their expected bundles; rst/redirect flush them.
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      exp_line = RPC[29:2];
      exp_off  = RPC[1:0];
    end else if (redirect_valid) begin
      exp_q.delete();
      exp_line = redirect_pc[29:2];
      exp_off  = redirect_pc[1:0];
    end else begin
      if (out_valid && out_ready) begin
        cons_cnt++;
        if (exp_q.size() == 0) begin
          check_eq("sb_unexpected_bundle", {98'd0, out_pc}, 128'h0);
        end else begin
          e = exp_q.pop_front();
          check_eq("sb_pc", {98'd0, out_pc}, {98'd0, e.pc});
          check_eq("sb_mask", {126'd0, out_mask}, {126'd0, e.mask});
          check_eq("sb_enc", {64'd0, out_enc & lane_bits(out_mask)}, {64'd0, e.enc});
        end
      end
      if (req_valid && req_ready) begin
        acc_cnt++;
        check_eq("sb_req_addr", {100'd0, req_addr}, {100'd0, exp_line});
        push_line(exp_line, exp_off);
        exp_line = exp_line + 28'd1;
        exp_off  = 2'b00;
      end
    end
  end

  logic [29:0] b_pc[3];
  logic [2:0]  b_mask[3];
  logic [95:0] b_enc[3];
  int          nb = 0;

  always @(negedge clk) begin
    if (!rst && b_out_valid && b_out_ready && nb < 3) begin
      b_pc[nb]   = b_out_pc;
      b_mask[nb] = b_out_mask;
      b_enc[nb]  = b_out_enc;
      nb++;
    end
  end

  task automatic wait_accept(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (req_valid && req_ready) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_fire(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (out_valid && out_ready) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  bit          ok;
  int          a0, c0;
  logic [27:0] held;

  initial begin
    rst = 1'b1; req_ready = 1'b1; out_ready = 1'b1; inject = 1'b0;
    redirect_valid = 1'b0; redirect_pc = '0;
    b_req_ready = 1'b1; b_out_ready = 1'b1; b_redirect_valid = 1'b0; b_redirect_pc = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("rst_out_valid", {127'd0, out_valid}, 128'd0);
    check_eq("rst_req_valid", {127'd0, req_valid}, 128'd0);
    check_eq("rst_out_mask", {126'd0, out_mask}, 128'd0);
    @(posedge clk); #1 rst = 1'b0;

    @(negedge clk);
    check_eq("c0_req_valid", {127'd0, req_valid}, 128'd1);
    check_eq("c0_req_addr", {100'd0, req_addr}, 128'd0);
    @(negedge clk);
    check_eq("c1_out_valid", {127'd0, out_valid}, 128'd0);
    check_eq("c1_req_addr", {100'd0, req_addr}, 128'd1);
    @(negedge clk);
    check_eq("c2_out_valid", {127'd0, out_valid}, 128'd1);
    check_eq("c2_out_pc", {98'd0, out_pc}, 128'd0);
    repeat (20) @(posedge clk);

    // Decode stall from an empty queue: credits allow exactly QD lines.
    #1 redirect_valid = 1'b1; redirect_pc = 30'h40; out_ready = 1'b0;
    @(posedge clk); #1 redirect_valid = 1'b0; a0 = acc_cnt;
    repeat (12) @(posedge clk);
    @(negedge clk);
    check_eq("stall_req_low", {127'd0, req_valid}, 128'd0);
    check_eq("stall_accepts", 128'(acc_cnt - a0), 128'd4);
    @(posedge clk); #1 c0 = cons_cnt; out_ready = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    check_eq("drain_count", 128'(cons_cnt - c0), 128'd8);
    check_eq("drain_resume", {127'd0, acc_cnt - a0 > 4}, 128'd1);

    // Redirect lands in the same cycle as a response, which must be dropped.
    wait_accept(ok);
    check_eq("redir_accept_seen", {127'd0, ok}, 128'd1);
    @(posedge clk); #1 redirect_valid = 1'b1; redirect_pc = 30'h7;
    @(posedge clk); #1 redirect_valid = 1'b0;
    wait_fire(ok);
    check_eq("redir_b0_seen", {127'd0, ok}, 128'd1);
    check_eq("redir_b0_pc", {98'd0, out_pc}, 128'h7);
    check_eq("redir_b0_mask", {126'd0, out_mask}, 128'h1);
    wait_fire(ok);
    check_eq("redir_b1_pc", {98'd0, out_pc}, 128'h8);
    check_eq("redir_b1_mask", {126'd0, out_mask}, 128'h3);

    // Cache back-pressure: address held, no duplicate request afterwards.
    @(posedge clk); #1 req_ready = 1'b0;
    @(negedge clk); held = req_addr;
    repeat (3) begin
      @(negedge clk);
      check_eq("hold_addr", {100'd0, req_addr}, {100'd0, held});
    end
    check_eq("hold_valid", {127'd0, req_valid}, 128'd1);
    @(posedge clk); #1 req_ready = 1'b1;
    repeat (10) @(posedge clk);

    // Reset while a response is in flight, then a stray response with no request.
    wait_accept(ok);
    check_eq("rst_accept_seen", {127'd0, ok}, 128'd1);
    @(posedge clk); #1 rst = 1'b1; inject = 1'b1;
    @(posedge clk); #1 rst = 1'b0; inject = 1'b0;
    @(negedge clk);
    check_eq("post_rst_out_valid", {127'd0, out_valid}, 128'd0);
    check_eq("post_rst_count", 128'(dut.u_queue.count_o), 128'd0);
    check_eq("post_rst_req_addr", {100'd0, req_addr}, {100'd0, RPC[29:2]});
    @(negedge clk);
    check_eq("post_rst_stray_ignored", {127'd0, out_valid}, 128'd0);
    @(negedge clk);
    check_eq("post_rst_first_pc", {98'd0, out_pc}, {98'd0, RPC});
    repeat (10) @(posedge clk);

    check_eq("w3_count", 128'(nb), 128'd3);
    check_eq("w3_b0_pc", {98'd0, b_pc[0]}, 128'd0);
    check_eq("w3_b0_mask", {125'd0, b_mask[0]}, 128'h7);
    check_eq("w3_b1_pc", {98'd0, b_pc[1]}, 128'd3);
    check_eq("w3_b1_mask", {125'd0, b_mask[1]}, 128'h1);
    check_eq("w3_b1_lane0", {96'd0, b_enc[1][31:0]}, {96'd0, enc_of(30'd3)});
    check_eq("w3_b2_pc", {98'd0, b_pc[2]}, 128'd4);
    check_eq("w3_b2_mask", {125'd0, b_mask[2]}, 128'h7);
    check_eq("w3_b2_lane2", {96'd0, b_enc[2][95:64]}, {96'd0, enc_of(30'd6)});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
